// File: rtl/hpi_bus_sequencer_pkg.sv
// Shared types and constants for the CY7C67200 HPI bus sequencer.
package hpi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_DONE    = 3'd4,
    ST_RECOVER = 3'd5
  } hpi_state_e;

  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDRESS = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;

  localparam int HPI_DATA_W = 16;

endpackage

// File: rtl/hpi_bus_sequencer_phase_timer.sv
// Loadable 8-bit down-counter with zero flag; times every phase of an HPI cycle.
module hpi_phase_timer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic       zero_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == 8'd0);

endmodule

// File: rtl/hpi_bus_sequencer.sv
// Avalon-MM slave that runs one timed CY7C67200 HPI bus cycle per CPU access.
// Optional macro HPI_IRQ_EN adds a synchronized otg_int -> irq path.
module hpi_bus_sequencer
  import hpi_pkg::*;
#(
  parameter int SETUP_CYC   = 2,
  parameter int STROBE_CYC  = 4,
  parameter int HOLD_CYC    = 2,
  parameter int RECOVER_CYC = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  read,
  input  logic                  write,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic                  waitrequest,
  output logic [1:0]            otg_addr,
  output logic                  otg_cs_n,
  output logic                  otg_rd_n,
  output logic                  otg_wr_n,
  output logic [HPI_DATA_W-1:0] otg_data_out,
  output logic                  otg_data_oe,
`ifdef HPI_IRQ_EN
  input  logic                  otg_int,
  output logic                  irq,
`endif
  input  logic [HPI_DATA_W-1:0] otg_data_in
);

  hpi_state_e            state_q, state_d;
  logic [1:0]            addr_q, addr_d;
  logic [HPI_DATA_W-1:0] data_q, data_d;
  logic                  wr_q, wr_d;
  logic [HPI_DATA_W-1:0] rdata_q;
  logic                  cs_n_q, rd_n_q, wr_n_q, oe_q;
  logic                  cs_n_d, rd_n_d, wr_n_d, oe_d;
  logic                  req, accept, capture, bus_active;
  logic                  tmr_load, tmr_zero;
  logic [7:0]            tmr_val;
  logic                  unused_wdata_hi;

  assign unused_wdata_hi = ^writedata[31:HPI_DATA_W];

  assign req         = chipselect & (read | write);
  assign waitrequest = req & (state_q != ST_DONE);

  hpi_phase_timer u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  // A request pending at the end of RECOVER is taken directly, so the next
  // SETUP starts RECOVER_CYC+1 cycles after DONE.
  assign accept = req & ((state_q == ST_IDLE) |
                         ((state_q == ST_RECOVER) & tmr_zero));

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    wr_d     = wr_q;
    tmr_load = 1'b0;
    tmr_val  = 8'd0;
    capture  = 1'b0;

    unique case (state_q)
      ST_IDLE: ;
      ST_SETUP: begin
        if (tmr_zero) begin
          state_d  = ST_STROBE;
          tmr_load = 1'b1;
          tmr_val  = 8'(STROBE_CYC - 1);
        end
      end
      ST_STROBE: begin
        if (tmr_zero) begin
          state_d  = ST_HOLD;
          tmr_load = 1'b1;
          tmr_val  = 8'(HOLD_CYC - 1);
          capture  = ~wr_q;
        end
      end
      ST_HOLD: begin
        if (tmr_zero) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d  = ST_RECOVER;
        tmr_load = 1'b1;
        tmr_val  = 8'(RECOVER_CYC - 1);
      end
      ST_RECOVER: begin
        if (tmr_zero) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Write wins when read and write are both asserted.
    if (accept) begin
      state_d  = ST_SETUP;
      addr_d   = address;
      data_d   = writedata[HPI_DATA_W-1:0];
      wr_d     = write;
      tmr_load = 1'b1;
      tmr_val  = 8'(SETUP_CYC - 1);
    end

    // Pin values are decoded from the next state so they change with the state.
    bus_active = (state_d == ST_SETUP) | (state_d == ST_STROBE) | (state_d == ST_HOLD);
    cs_n_d     = ~bus_active;
    rd_n_d     = ~((state_d == ST_STROBE) & ~wr_d);
    wr_n_d     = ~((state_d == ST_STROBE) & wr_d);
    oe_d       = bus_active & wr_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= 2'd0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      cs_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      cs_n_q  <= cs_n_d;
      rd_n_q  <= rd_n_d;
      wr_n_q  <= wr_n_d;
      oe_q    <= oe_d;
      if (capture) rdata_q <= otg_data_in;
    end
  end

  assign readdata     = {{(32-HPI_DATA_W){1'b0}}, rdata_q};
  assign otg_addr     = addr_q;
  assign otg_data_out = data_q;
  assign otg_cs_n     = cs_n_q;
  assign otg_rd_n     = rd_n_q;
  assign otg_wr_n     = wr_n_q;
  assign otg_data_oe  = oe_q;

`ifdef HPI_IRQ_EN
  logic [1:0] int_sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      int_sync_q <= 2'b00;
    end else begin
      int_sync_q <= {int_sync_q[0], otg_int};
    end
  end

  assign irq = int_sync_q[1];
`endif

endmodule
